// File: rtl/axil_cmd_master.sv
// Turns simple valid/ready commands into single AXI-Lite reads or writes.
// One transaction is in flight at a time; the response is held until yumi_i.
module axil_cmd_master #(
    parameter int addr_width_p = 10,
    parameter int data_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      v_i,
    output logic                      ready_o,
    input  logic                      w_i,
    input  logic [addr_width_p-1:0]   addr_i,
    input  logic [data_width_p-1:0]   data_i,

    output logic                      v_o,
    input  logic                      yumi_i,
    output logic [data_width_p-1:0]   data_o,
    output logic                      err_o,

    output logic [addr_width_p-1:0]   m_axil_awaddr,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,

    output logic [data_width_p-1:0]   m_axil_wdata,
    output logic [data_width_p/8-1:0] m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,

    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,

    output logic [addr_width_p-1:0]   m_axil_araddr,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,

    input  logic [data_width_p-1:0]   m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready
);

    typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R, RESP} state_e;

    state_e                    state_q;
    logic [addr_width_p-1:0]   addr_q;
    logic [data_width_p-1:0]   wdata_q;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      arvalid_q;
    logic                      v_q;
    logic [data_width_p-1:0]   data_q;
    logic                      err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            v_q       <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_i) begin
                        addr_q <= addr_i;
                        if (w_i) begin
                            wdata_q   <= data_i;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD;
                        end
                    end
                end
                WR: begin
                    // AW and W retire independently; leave once neither is still pending.
                    if (m_axil_awready) awvalid_q <= 1'b0;
                    if (m_axil_wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready))
                        state_q <= WAIT_B;
                end
                WAIT_B: begin
                    if (m_axil_bvalid) begin
                        data_q  <= '0;
                        err_q   <= |m_axil_bresp;
                        v_q     <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RD: begin
                    if (m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (m_axil_rvalid) begin
                        data_q  <= m_axil_rdata;
                        err_q   <= |m_axil_rresp;
                        v_q     <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (yumi_i) begin
                        v_q     <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o        = (state_q == IDLE);
    assign v_o            = v_q;
    assign data_o         = data_q;
    assign err_o          = err_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = (state_q == WAIT_B);
    assign m_axil_araddr  = addr_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = (state_q == WAIT_R);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a vector table drives a cycle-accurate
// AXI-Lite slave model, plus hand-written reset sequences.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0, w_i = 1'b0, yumi_i = 1'b0;
    logic [9:0]  addr_i = '0;
    logic [31:0] data_i = '0;
    logic        ready_o, v_o, err_o;
    logic [31:0] data_o;
    logic [9:0]  awaddr, araddr;
    logic        awvalid, awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0, bready;
    logic        arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0, rready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axil_cmd_master #(.addr_width_p(10), .data_width_p(32)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .v_i(v_i), .ready_o(ready_o), .w_i(w_i), .addr_i(addr_i), .data_i(data_i),
        .v_o(v_o), .yumi_i(yumi_i), .data_o(data_o), .err_o(err_o),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    // a_dly doubles as the AR delay for reads; r_dly delays B or R after the request completes.
    typedef struct {
        logic        w;
        logic [9:0]  addr;
        logic [31:0] data;
        int          a_dly;
        int          w_dly;
        int          r_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          yumi_dly;
        bit          hold;
        bit          stray;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0, rsp_cnt = 0;
        int  t_done = 1000, rt = 0;
        bit  yumi_done = 0, seen_v = 0, finished = 0, both, respv;
        chk("ready_before_cmd", ready_o, 1);
        v_i = 1'b1; w_i = v.w; addr_i = v.addr; data_i = v.data;
        @(negedge clk);
        if (v.hold) begin
            addr_i = ~v.addr; data_i = ~v.data;
        end else begin
            v_i = 1'b0;
        end
        for (int t = 1; t <= 60; t++) begin
            if (yumi_done) begin
                chk("ready_after_yumi", ready_o, 1);
                chk("v_o_after_yumi", v_o, 0);
                finished = 1;
                break;
            end
            chk("ready_busy", ready_o, 0);
            chk("awvalid", awvalid, (v.w && aw_cnt == 0) ? 1 : 0);
            chk("wvalid", wvalid, (v.w && w_cnt == 0) ? 1 : 0);
            chk("arvalid", arvalid, (!v.w && ar_cnt == 0) ? 1 : 0);
            chk("bready", bready, (v.w && aw_cnt > 0 && w_cnt > 0 && rsp_cnt == 0) ? 1 : 0);
            chk("rready", rready, (!v.w && ar_cnt > 0 && rsp_cnt == 0) ? 1 : 0);
            chk("v_o", v_o, (rsp_cnt > 0) ? 1 : 0);
            if (awvalid) chk("awaddr", {22'd0, awaddr}, {22'd0, v.addr});
            if (wvalid) begin
                chk("wdata", wdata, v.data);
                chk("wstrb", {28'd0, wstrb}, 32'hF);
            end
            if (arvalid) chk("araddr", {22'd0, araddr}, {22'd0, v.addr});
            if (v_o === 1'b1 && !seen_v) begin
                seen_v = 1;
                chk("latency", t, v.exp_lat);
            end
            if (rsp_cnt > 0) begin
                chk("data_o", data_o, v.exp_data);
                chk("err_o", err_o, v.exp_err);
                rt++;
                yumi_i = (rt > v.yumi_dly);
            end
            awready = v.w && (t >= 1 + v.a_dly);
            wready  = v.w && (t >= 1 + v.w_dly);
            arready = !v.w && (t >= 1 + v.a_dly);
            both    = v.w ? (aw_cnt > 0 && w_cnt > 0) : (ar_cnt > 0);
            respv   = both && rsp_cnt == 0 && (t >= t_done + 1 + v.r_dly);
            bvalid  = v.w ? respv : v.stray;
            rvalid  = v.w ? v.stray : respv;
            bresp   = v.w ? v.resp : 2'd3;
            rresp   = v.w ? 2'd3 : v.resp;
            rdata   = v.w ? 32'hBAD0BAD0 : v.rdata;
            if (awvalid && awready) aw_cnt++;
            if (wvalid && wready) w_cnt++;
            if (arvalid && arready) ar_cnt++;
            if (t_done == 1000 && (v.w ? (aw_cnt > 0 && w_cnt > 0) : (ar_cnt > 0))) t_done = t;
            if (v.w ? (bvalid && bready) : (rvalid && rready)) rsp_cnt++;
            if (yumi_i && v_o) yumi_done = 1;
            @(negedge clk);
        end
        if (!finished) chk($sformatf("timeout_vec%0d", idx), 0, 1);
        chk("single_aw", aw_cnt, v.w ? 1 : 0);
        chk("single_resp", rsp_cnt, 1);
        yumi_i = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0;
    endtask

    initial begin
        //           w     addr     data          a  w  r  resp  rdata         y  hold stray exp_data      err lat
        vecs[0] = '{1'b1, 10'h010, 32'hDEADBEEF, 0, 0, 0, 2'd0, 32'h0,        0, 0,   0,    32'h0,        1'b0, 3};
        vecs[1] = '{1'b0, 10'h3FC, 32'h0,        0, 0, 0, 2'd0, 32'h12345678, 3, 0,   0,    32'h12345678, 1'b0, 3};
        vecs[2] = '{1'b1, 10'h104, 32'hCAFEF00D, 0, 5, 0, 2'd0, 32'h0,        0, 0,   0,    32'h0,        1'b0, 8};
        vecs[3] = '{1'b0, 10'h020, 32'h0,        1, 0, 1, 2'd2, 32'h0BADC0DE, 1, 0,   1,    32'h0BADC0DE, 1'b1, 5};
        vecs[4] = '{1'b1, 10'h2A8, 32'h55AA55AA, 3, 0, 2, 2'd1, 32'h0,        0, 0,   1,    32'h0,        1'b1, 8};
        vecs[5] = '{1'b1, 10'h0F0, 32'hA5A5A5A5, 0, 0, 0, 2'd0, 32'h0,        2, 1,   0,    32'h0,        1'b0, 3};
        vecs[6] = '{1'b0, 10'h000, 32'h0,        2, 0, 3, 2'd0, 32'h89ABCDEF, 0, 0,   0,    32'h89ABCDEF, 1'b0, 8};
        vecs[7] = '{1'b1, 10'h3FF, 32'h00000001, 2, 2, 1, 2'd0, 32'h0,        0, 0,   0,    32'h0,        1'b0, 6};
        vecs[8] = '{1'b0, 10'h1C4, 32'h0,        0, 0, 2, 2'd3, 32'hFEEDFACE, 1, 0,   0,    32'hFEEDFACE, 1'b1, 5};

        repeat (2) @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_v_o", v_o, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_err_o", err_o, 0);
        reset_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
            $display("vec %0d: %s addr=%h done, miscompares so far %0d",
                     i, vecs[i].w ? "WR" : "RD", vecs[i].addr, n_err);
        end

        // Reset while waiting for R: the late beat must not produce a response.
        v_i = 1'b1; w_i = 1'b0; addr_i = 10'h155;
        @(negedge clk);
        v_i = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("wr_rready_before_rst", rready, 1);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0; rvalid = 1'b1; rdata = 32'h77777777; rresp = 2'd0;
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_ready", ready_o, 1);
            chk("post_rst_v_o", v_o, 0);
            chk("post_rst_arvalid", arvalid, 0);
            chk("post_rst_rready", rready, 0);
            chk("post_rst_data_o", data_o, 0);
            chk("post_rst_err_o", err_o, 0);
            @(negedge clk);
        end
        rvalid = 1'b0;
        $display("reset-in-WAIT_R sequence done, miscompares so far %0d", n_err);

        run_vec(9, vecs[0]);
        $display("post-reset write done, miscompares so far %0d", n_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 The block SHALL have parameter addr_width_p, default 10, meaning AXI-Lite address width.
REQ-002 The block SHALL have parameter data_width_p, default 32, meaning AXI-Lite data width; only 32 is supported.
REQ-003 clk_i  input  1  single clock; all logic is rising-edge.
REQ-004 reset_i  input  1  reset, synchronous and active-high.
REQ-005 v_i  input  1  command valid.
REQ-006 ready_o  output  1  command accepted when v_i & ready_o.
REQ-007 w_i  input  1  1 = write command, 0 = read command.
REQ-008 addr_i  input  addr_width_p  command byte address; forwarded unmodified.
REQ-009 data_i  input  data_width_p  write data; ignored for reads.
REQ-010 v_o  output  1  response valid.
REQ-011 yumi_i  input  1  response consumed; legal only while v_o=1.
REQ-012 data_o  output  data_width_p  read data; 0 for write responses.
REQ-013 err_o  output  1  1 when the returned BRESP/RRESP is nonzero.
REQ-014 m_axil_awaddr/awvalid/awready  out/out/in  addr_width_p/1/1  AW channel.
REQ-015 m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  data_width_p/data_width_p/8/1/1  W channel; wstrb is constant all-ones.
REQ-016 m_axil_bresp/bvalid/bready  in/in/out  2/1/1  B channel.
REQ-017 m_axil_araddr/arvalid/arready  out/out/in  addr_width_p/1/1  AR channel.
REQ-018 m_axil_rdata/rresp/rvalid/rready  in/in/in/out  data_width_p/2/1/1  R channel.

Function
REQ-019 The FSM SHALL have states IDLE, WR, WAIT_B, RD, WAIT_R and RESP, with one transaction outstanding at a time.
REQ-020 ready_o SHALL equal (state==IDLE); a command accepted in cycle N SHALL register addr, data and kind, and drive the AXI valid outputs from cycle N+1.
REQ-021 IDLE handling SHALL be: on a write command, go to WR with awvalid=wvalid=1; on a read command, go to RD with arvalid=1.
REQ-022 In WR, awvalid SHALL drop the cycle after its own handshake, and wvalid SHALL drop the cycle after its own handshake.
REQ-023 The AW and W handshakes in WR MAY complete in either order or in the same cycle, and the FSM SHALL go to WAIT_B once both are done.
REQ-024 awaddr, wdata, araddr and every valid SHALL stay stable from assertion until handshake (no retraction).
REQ-025 bready SHALL be 1 only in WAIT_B and rready SHALL be 1 only in WAIT_R; a bvalid/rvalid seen in any other state SHALL be ignored.
REQ-026 In RD, arvalid SHALL hold until arready, and the FSM SHALL then go to WAIT_R.
REQ-027 A B or R handshake SHALL capture the response (data_o=rdata or 0, err_o=(resp!=0)), and the FSM SHALL go to RESP with v_o=1 from the next cycle.
REQ-028 In RESP, v_o, data_o and err_o SHALL hold until yumi_i, after which the FSM SHALL return to IDLE with ready_o=1 the following cycle.
REQ-029 Minimum command-to-v_o latency SHALL be 3 cycles when every AXI ready/valid is 1 at first opportunity.
REQ-030 A v_i asserted in any non-IDLE state SHALL NOT be accepted and SHALL NOT alter in-flight state.

Reset
REQ-031 While reset_i=1, state SHALL go to IDLE and ready_o SHALL be 1 after the reset cycle; awvalid, wvalid, arvalid, bready, rready, v_o, err_o and data_o SHALL be 0.
REQ-032 A reset asserted mid-transaction SHALL abandon that transaction with no response, and any late B/R beat SHALL be ignored.

Verification
REQ-033 Write addr 0x010, data 0xDEADBEEF, all readies=1: awaddr=0x010, wdata=0xDEADBEEF, wstrb=0xF, then v_o=1, err_o=0, data_o=0 three cycles after acceptance.
REQ-034 Read addr 0x3FC, rdata=0x12345678, rresp=0: v_o=1 with data_o=0x12345678, err_o=0, held for 4 cycles until yumi_i.
REQ-035 Write with wready 5 cycles later than awready: awvalid drops after its handshake, wvalid holds until its own, exactly one B accepted, and one response.
REQ-036 Read with rresp=2 (SLVERR): v_o=1, err_o=1, data_o=rdata.
REQ-037 v_i held high through a whole transaction: second command accepted only in the cycle ready_o returns to 1, and no duplicate AXI transaction is issued.
REQ-038 reset_i pulsed while in WAIT_R, then rvalid=1: no v_o, all valids 0, ready_o=1 after reset.
